// File: rtl/memory_stage.sv
// Memory stage of the pipelined Y86-64 core.
// Holds the E->M pipeline register, performs the 64-bit little-endian data
// memory access for the instruction in M, and drives the M->W register.
// Optional build macro: DMEM_PRELOAD_EN adds a byte-wide preload port
// (pl_we/pl_addr/pl_data) into the data memory.
module memory_stage #(
    parameter int MEM_BYTES = 1024,
    parameter int AW        = 64
) (
    input  logic          clk,
    input  logic          reset,
`ifdef DMEM_PRELOAD_EN
    input  logic          pl_we,
    input  logic [AW-1:0] pl_addr,
    input  logic [7:0]    pl_data,
`endif
    input  logic [2:0]    e_stat,
    input  logic [3:0]    e_icode,
    input  logic          e_cnd,
    input  logic [AW-1:0] e_valE,
    input  logic [AW-1:0] e_valA,
    input  logic [3:0]    e_dstE,
    input  logic [3:0]    e_dstM,
    input  logic          m_stall,
    input  logic          m_bubble,
    input  logic          w_stall,
    output logic [3:0]    M_icode,
    output logic          M_cnd,
    output logic [AW-1:0] M_valE,
    output logic [AW-1:0] M_valA,
    output logic [3:0]    M_dstE,
    output logic [3:0]    M_dstM,
    output logic [2:0]    M_stat,
    output logic [63:0]   m_valM,
    output logic [2:0]    m_stat,
    output logic [2:0]    W_stat,
    output logic [3:0]    W_icode,
    output logic [AW-1:0] W_valE,
    output logic [63:0]   W_valM,
    output logic [3:0]    W_dstE,
    output logic [3:0]    W_dstM
);

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [3:0] IC_NOP   = 4'd1;
    localparam logic [3:0] REG_NONE = 4'hF;
    localparam int         IW       = $clog2(MEM_BYTES);

    logic [7:0]    mem [MEM_BYTES];
    logic [AW-1:0] mem_addr;
    logic [IW-1:0] idx;
    logic          is_read;
    logic          is_write;
    logic          addr_ok;
    logic          do_write;
    logic [63:0]   rd_data;

    // Decode access type and address source; the bound check is done one bit
    // wider than the address so addresses near 2^AW cannot wrap into range.
    always_comb begin
        is_read  = (M_icode == 4'd5) || (M_icode == 4'd9) || (M_icode == 4'd11);
        is_write = (M_icode == 4'd4) || (M_icode == 4'd8) || (M_icode == 4'd10);
        mem_addr = ((M_icode == 4'd9) || (M_icode == 4'd11)) ? M_valA : M_valE;
        addr_ok  = ({1'b0, mem_addr} + (AW+1)'(7)) < (AW+1)'(MEM_BYTES);
        idx      = mem_addr[IW-1:0];
        // A store behind a faulted instruction in W must not change memory.
        do_write = !reset && (M_stat == STAT_AOK) && is_write && addr_ok
                   && (W_stat == STAT_AOK);
    end

    // Combinational 8-byte little-endian read; zero when not reading or out of range.
    always_comb begin
        rd_data = '0;
        if (is_read && addr_ok) begin
            for (int i = 0; i < 8; i++) begin
                rd_data[8*i +: 8] = mem[idx + IW'(i)];
            end
        end
    end

    // Stage status and read data exposed for forwarding and hazard logic.
    always_comb begin
        m_valM = rd_data;
        m_stat = ((is_read || is_write) && !addr_ok) ? STAT_ADR : M_stat;
    end

    // Data memory writes; never reset so preloaded or stored contents survive reset.
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int i = 0; i < 8; i++) begin
                mem[idx + IW'(i)] <= M_valA[8*i +: 8];
            end
        end
`ifdef DMEM_PRELOAD_EN
        // Placed last so a preload wins over a pipeline store to the same byte.
        if (pl_we && ({1'b0, pl_addr} < (AW+1)'(MEM_BYTES))) begin
            mem[pl_addr[IW-1:0]] <= pl_data;
        end
`endif
    end

    // M pipeline register: reset > bubble > stall > load.
    always_ff @(posedge clk) begin
        if (reset || m_bubble) begin
            M_stat  <= STAT_AOK;
            M_icode <= IC_NOP;
            M_cnd   <= 1'b0;
            M_valE  <= '0;
            M_valA  <= '0;
            M_dstE  <= REG_NONE;
            M_dstM  <= REG_NONE;
        end else if (!m_stall) begin
            M_stat  <= e_stat;
            M_icode <= e_icode;
            M_cnd   <= e_cnd;
            M_valE  <= e_valE;
            M_valA  <= e_valA;
            M_dstE  <= e_dstE;
            M_dstM  <= e_dstM;
        end
    end

    // W pipeline register: reset > stall > load.
    always_ff @(posedge clk) begin
        if (reset) begin
            W_stat  <= STAT_AOK;
            W_icode <= IC_NOP;
            W_valE  <= '0;
            W_valM  <= '0;
            W_dstE  <= REG_NONE;
            W_dstM  <= REG_NONE;
        end else if (!w_stall) begin
            W_stat  <= m_stat;
            W_icode <= M_icode;
            W_valE  <= M_valE;
            W_valM  <= m_valM;
            W_dstE  <= M_dstE;
            W_dstM  <= M_dstM;
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Testbench for memory_stage: directed scenarios plus a randomized instruction
// stream checked against a byte-array memory model.
module tb_memory_stage;

    localparam int MEM_BYTES = 1024;

    logic        clk;
    logic        reset;
    logic [2:0]  e_stat;
    logic [3:0]  e_icode;
    logic        e_cnd;
    logic [63:0] e_valE;
    logic [63:0] e_valA;
    logic [3:0]  e_dstE;
    logic [3:0]  e_dstM;
    logic        m_stall;
    logic        m_bubble;
    logic        w_stall;
    logic [3:0]  M_icode;
    logic        M_cnd;
    logic [63:0] M_valE;
    logic [63:0] M_valA;
    logic [3:0]  M_dstE;
    logic [3:0]  M_dstM;
    logic [2:0]  M_stat;
    logic [63:0] m_valM;
    logic [2:0]  m_stat;
    logic [2:0]  W_stat;
    logic [3:0]  W_icode;
    logic [63:0] W_valE;
    logic [63:0] W_valM;
    logic [3:0]  W_dstE;
    logic [3:0]  W_dstM;

    int checks = 0;
    int errors = 0;

    logic [7:0] ref_mem [MEM_BYTES];

    memory_stage #(.MEM_BYTES(MEM_BYTES), .AW(64)) dut (
        .clk(clk), .reset(reset),
        .e_stat(e_stat), .e_icode(e_icode), .e_cnd(e_cnd),
        .e_valE(e_valE), .e_valA(e_valA), .e_dstE(e_dstE), .e_dstM(e_dstM),
        .m_stall(m_stall), .m_bubble(m_bubble), .w_stall(w_stall),
        .M_icode(M_icode), .M_cnd(M_cnd), .M_valE(M_valE), .M_valA(M_valA),
        .M_dstE(M_dstE), .M_dstM(M_dstM), .M_stat(M_stat),
        .m_valM(m_valM), .m_stat(m_stat),
        .W_stat(W_stat), .W_icode(W_icode), .W_valE(W_valE), .W_valM(W_valM),
        .W_dstE(W_dstE), .W_dstM(W_dstM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] st, input logic [3:0] ic,
                         input logic [63:0] ve, input logic [63:0] va,
                         input logic [3:0] de, input logic [3:0] dm);
        e_stat  = st;
        e_icode = ic;
        e_cnd   = 1'b0;
        e_valE  = ve;
        e_valA  = va;
        e_dstE  = de;
        e_dstM  = dm;
        step();
    endtask

    task automatic nop();
        drive(3'd1, 4'd1, 64'd0, 64'd0, 4'hF, 4'hF);
    endtask

    // Store then a NOP so the write has landed before the next instruction.
    task automatic store(input logic [63:0] a, input logic [63:0] d);
        drive(3'd1, 4'd4, a, d, 4'hF, 4'hF);
        nop();
        for (int i = 0; i < 8; i++) ref_mem[int'(a) + i] = d[8*i +: 8];
    endtask

    function automatic logic valid_addr(input logic [63:0] a);
        return a <= 64'(MEM_BYTES - 8);
    endfunction

    function automatic logic [63:0] ref_read(input logic [63:0] a);
        logic [63:0] r;
        r = 64'd0;
        for (int i = 0; i < 8; i++) r = r | (64'(ref_mem[int'(a) + i]) << (8 * i));
        return r;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        e_stat = 3'd4; e_icode = 4'd5; e_cnd = 1'b1;
        e_valE = {$urandom, $urandom}; e_valA = {$urandom, $urandom};
        e_dstE = 4'd3; e_dstM = 4'd4;
        step();
        step();
        checks++; if (M_icode !== 4'd1) begin errors++; $display("FAIL rst_M_icode got %h exp 1", M_icode); end
        checks++; if (M_stat !== 3'd1) begin errors++; $display("FAIL rst_M_stat got %h exp 1", M_stat); end
        checks++; if (M_cnd !== 1'b0 || M_valE !== 64'd0 || M_valA !== 64'd0) begin errors++; $display("FAIL rst_M_vals got %b %h %h exp 0 0 0", M_cnd, M_valE, M_valA); end
        checks++; if (M_dstE !== 4'hF || M_dstM !== 4'hF) begin errors++; $display("FAIL rst_M_dst got %h %h exp f f", M_dstE, M_dstM); end
        checks++; if (W_stat !== 3'd1 || W_icode !== 4'd1) begin errors++; $display("FAIL rst_W_stat_icode got %h %h exp 1 1", W_stat, W_icode); end
        checks++; if (W_valE !== 64'd0 || W_valM !== 64'd0 || W_dstE !== 4'hF || W_dstM !== 4'hF) begin errors++; $display("FAIL rst_W_vals got %h %h %h %h exp 0 0 f f", W_valE, W_valM, W_dstE, W_dstM); end
        checks++; if (m_valM !== 64'd0 || m_stat !== 3'd1) begin errors++; $display("FAIL rst_m_out got %h %h exp 0 1", m_valM, m_stat); end
        reset = 1'b0;
        nop();
    endtask

    task automatic test_store_load();
        drive(3'd1, 4'd4, 64'h40, 64'h1122334455667788, 4'hF, 4'hF);
        checks++; if (m_stat !== 3'd1 || m_valM !== 64'd0) begin errors++; $display("FAIL st_m_out got %h %h exp 1 0", m_stat, m_valM); end
        drive(3'd1, 4'd5, 64'h40, 64'd0, 4'hF, 4'd3);
        checks++; if (m_valM !== 64'h1122334455667788) begin errors++; $display("FAIL ld_valM got %h exp 1122334455667788", m_valM); end
        checks++; if (m_valM[7:0] !== 8'h88) begin errors++; $display("FAIL ld_byte40 got %h exp 88", m_valM[7:0]); end
        nop();
        checks++; if (W_valM !== 64'h1122334455667788 || W_dstM !== 4'd3 || W_icode !== 4'd5) begin errors++; $display("FAIL ld_W got %h %h %h exp 1122334455667788 3 5", W_valM, W_dstM, W_icode); end
        for (int i = 0; i < 8; i++) ref_mem[16'h40 + i] = 8'(64'h1122334455667788 >> (8 * i));
    endtask

    task automatic test_stack();
        drive(3'd1, 4'd10, 64'h1F8, 64'hAB, 4'd4, 4'hF);
        drive(3'd1, 4'd11, 64'h200, 64'h1F8, 4'd4, 4'd5);
        checks++; if (m_valM !== 64'hAB) begin errors++; $display("FAIL pop_valM got %h exp ab", m_valM); end
        nop();
        checks++; if (W_valE !== 64'h200 || W_dstE !== 4'd4 || W_valM !== 64'hAB || W_dstM !== 4'd5) begin errors++; $display("FAIL pop_W got %h %h %h %h exp 200 4 ab 5", W_valE, W_dstE, W_valM, W_dstM); end
        drive(3'd1, 4'd8, 64'h1F0, 64'h1234, 4'd4, 4'hF);
        drive(3'd1, 4'd9, 64'h1F8, 64'h1F0, 4'd4, 4'hF);
        checks++; if (m_valM !== 64'h1234) begin errors++; $display("FAIL ret_valM got %h exp 1234", m_valM); end
        nop();
    endtask

    task automatic test_bad_addr();
        store(64'h80, 64'h5555666677778888);
        store(64'(MEM_BYTES - 8), 64'h0102030405060708);
        drive(3'd1, 4'd5, 64'(MEM_BYTES - 4), 64'd0, 4'hF, 4'd2);
        checks++; if (m_stat !== 3'd3 || m_valM !== 64'd0) begin errors++; $display("FAIL bad_rd got %h %h exp 3 0", m_stat, m_valM); end
        drive(3'd1, 4'd4, 64'h80, 64'hDEADBEEFDEADBEEF, 4'hF, 4'hF);
        checks++; if (W_stat !== 3'd3) begin errors++; $display("FAIL bad_W_stat got %h exp 3", W_stat); end
        checks++; if (m_stat !== 3'd1) begin errors++; $display("FAIL blocked_st_mstat got %h exp 1", m_stat); end
        nop();
        drive(3'd1, 4'd5, 64'h80, 64'd0, 4'hF, 4'd2);
        checks++; if (m_valM !== 64'h5555666677778888) begin errors++; $display("FAIL blocked_st_mem got %h exp 5555666677778888", m_valM); end
        drive(3'd1, 4'd5, 64'(MEM_BYTES - 8), 64'd0, 4'hF, 4'd2);
        checks++; if (m_stat !== 3'd1 || m_valM !== 64'h0102030405060708) begin errors++; $display("FAIL edge_rd got %h %h exp 1 0102030405060708", m_stat, m_valM); end
        drive(3'd1, 4'd5, 64'(MEM_BYTES - 7), 64'd0, 4'hF, 4'd2);
        checks++; if (m_stat !== 3'd3 || m_valM !== 64'd0) begin errors++; $display("FAIL edge_bad got %h %h exp 3 0", m_stat, m_valM); end
        nop();
        nop();
    endtask

    task automatic test_wrap();
        store(64'h3F8, 64'hA1A2A3A4A5A6A7A8);
        store(64'h0, 64'hB1B2B3B4B5B6B7B8);
        drive(3'd1, 4'd4, 64'hFFFFFFFFFFFFFFFC, 64'hC1C2C3C4C5C6C7C8, 4'hF, 4'hF);
        checks++; if (m_stat !== 3'd3) begin errors++; $display("FAIL wrap_stat got %h exp 3", m_stat); end
        nop();
        nop();
        drive(3'd1, 4'd5, 64'h3F8, 64'd0, 4'hF, 4'd1);
        checks++; if (m_valM !== 64'hA1A2A3A4A5A6A7A8) begin errors++; $display("FAIL wrap_mem_top got %h exp a1a2a3a4a5a6a7a8", m_valM); end
        drive(3'd1, 4'd5, 64'h0, 64'd0, 4'hF, 4'd1);
        checks++; if (m_valM !== 64'hB1B2B3B4B5B6B7B8) begin errors++; $display("FAIL wrap_mem_low got %h exp b1b2b3b4b5b6b7b8", m_valM); end
        nop();
    endtask

    task automatic test_stall_bubble();
        drive(3'd1, 4'd5, 64'h40, 64'd0, 4'hF, 4'd3);
        m_stall = 1'b1;
        drive(3'd1, 4'd6, 64'h55, 64'd0, 4'd2, 4'hF);
        checks++; if (M_icode !== 4'd5 || W_icode !== 4'd5) begin errors++; $display("FAIL stall1 got %h %h exp 5 5", M_icode, W_icode); end
        step();
        checks++; if (M_icode !== 4'd5 || M_dstM !== 4'd3 || m_valM !== 64'h1122334455667788) begin errors++; $display("FAIL stall2 got %h %h %h exp 5 3 1122334455667788", M_icode, M_dstM, m_valM); end
        m_bubble = 1'b1;
        step();
        checks++; if (M_icode !== 4'd1 || M_dstE !== 4'hF || M_dstM !== 4'hF || M_valE !== 64'd0) begin errors++; $display("FAIL bubble got %h %h %h %h exp 1 f f 0", M_icode, M_dstE, M_dstM, M_valE); end
        m_bubble = 1'b0;
        m_stall = 1'b0;
        drive(3'd1, 4'd6, 64'h77, 64'd0, 4'd2, 4'hF);
        drive(3'd1, 4'd3, 64'h99, 64'd0, 4'd7, 4'hF);
        w_stall = 1'b1;
        nop();
        checks++; if (W_icode !== 4'd6 || W_valE !== 64'h77 || W_dstE !== 4'd2) begin errors++; $display("FAIL wstall_hold got %h %h %h exp 6 77 2", W_icode, W_valE, W_dstE); end
        checks++; if (M_icode !== 4'd1) begin errors++; $display("FAIL wstall_M_moves got %h exp 1", M_icode); end
        w_stall = 1'b0;
        step();
        checks++; if (W_icode !== 4'd1) begin errors++; $display("FAIL wstall_release got %h exp 1", W_icode); end
    endtask

    task automatic test_reset_mid();
        store(64'h100, 64'h0F0E0D0C0B0A0908);
        drive(3'd1, 4'd4, 64'h100, 64'h7777777777777777, 4'hF, 4'hF);
        reset = 1'b1;
        drive(3'd1, 4'd6, 64'h33, 64'd0, 4'd2, 4'hF);
        checks++; if (M_icode !== 4'd1 || M_valA !== 64'd0 || M_dstE !== 4'hF) begin errors++; $display("FAIL rstmid_M got %h %h %h exp 1 0 f", M_icode, M_valA, M_dstE); end
        checks++; if (W_icode !== 4'd1 || W_stat !== 3'd1 || W_dstM !== 4'hF) begin errors++; $display("FAIL rstmid_W got %h %h %h exp 1 1 f", W_icode, W_stat, W_dstM); end
        reset = 1'b0;
        drive(3'd1, 4'd5, 64'h100, 64'd0, 4'hF, 4'd1);
        checks++; if (m_valM !== 64'h0F0E0D0C0B0A0908) begin errors++; $display("FAIL rstmid_mem got %h exp 0f0e0d0c0b0a0908", m_valM); end
        nop();
        nop();
    endtask

    task automatic test_random();
        logic [3:0]  icodes [11] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11};
        logic [2:0]  st;
        logic [3:0]  ic, de, dm;
        logic [63:0] ve, va, a, exp_valM;
        logic [2:0]  exp_mstat;
        logic        rd, wr, bad;
        logic        have_prev;
        logic [2:0]  p_stat;
        logic [3:0]  p_icode, p_dstE, p_dstM;
        logic [63:0] p_valE, p_valM;
        logic [2:0]  cur_w_stat;
        int          r;

        for (int k = 0; k < MEM_BYTES / 8; k++) begin
            drive(3'd1, 4'd4, 64'(k * 8), {$urandom, $urandom}, 4'hF, 4'hF);
            for (int i = 0; i < 8; i++) ref_mem[k * 8 + i] = e_valA[8*i +: 8];
        end
        nop();
        nop();
        have_prev  = 1'b0;
        cur_w_stat = 3'd1;
        p_stat = 3'd0; p_icode = 4'd0; p_dstE = 4'd0; p_dstM = 4'd0; p_valE = 64'd0; p_valM = 64'd0;

        for (int n = 0; n < 300; n++) begin
            ic = icodes[$urandom_range(0, 10)];
            st = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
            ve = {$urandom, $urandom};
            va = {$urandom, $urandom};
            de = 4'($urandom_range(0, 15));
            dm = 4'($urandom_range(0, 15));
            r  = $urandom_range(0, 9);
            if (r < 7)       a = 64'($urandom_range(0, MEM_BYTES - 8));
            else if (r == 7) a = 64'($urandom_range(MEM_BYTES - 7, MEM_BYTES - 1));
            else if (r == 8) a = {$urandom | 32'h1, $urandom};
            else             a = 64'hFFFFFFFFFFFFFFF8 + 64'($urandom_range(0, 7));
            rd = (ic == 4'd5) || (ic == 4'd9) || (ic == 4'd11);
            wr = (ic == 4'd4) || (ic == 4'd8) || (ic == 4'd10);
            if ((ic == 4'd9) || (ic == 4'd11)) va = a;
            else ve = a;

            drive(st, ic, ve, va, de, dm);

            bad       = (rd || wr) && !valid_addr(a);
            exp_mstat = bad ? 3'd3 : st;
            exp_valM  = (rd && !bad) ? ref_read(a) : 64'd0;

            checks++; if (m_stat !== exp_mstat) begin errors++; $display("FAIL rnd_m_stat n=%0d ic=%0d got %h exp %h", n, ic, m_stat, exp_mstat); end
            checks++; if (m_valM !== exp_valM) begin errors++; $display("FAIL rnd_m_valM n=%0d ic=%0d a=%h got %h exp %h", n, ic, a, m_valM, exp_valM); end
            checks++; if (M_icode !== ic || M_valE !== ve || M_valA !== va || M_dstE !== de || M_dstM !== dm) begin errors++; $display("FAIL rnd_M_reg n=%0d got %h %h %h exp %h %h %h", n, M_icode, M_valE, M_valA, ic, ve, va); end
            if (have_prev) begin
                checks++; if (W_stat !== p_stat || W_icode !== p_icode || W_valE !== p_valE || W_valM !== p_valM || W_dstE !== p_dstE || W_dstM !== p_dstM) begin errors++; $display("FAIL rnd_W_reg n=%0d got %h %h %h %h exp %h %h %h %h", n, W_stat, W_icode, W_valE, W_valM, p_stat, p_icode, p_valE, p_valM); end
            end

            if (wr && (st == 3'd1) && !bad && (cur_w_stat == 3'd1)) begin
                for (int i = 0; i < 8; i++) ref_mem[int'(a) + i] = va[8*i +: 8];
            end
            p_stat = exp_mstat; p_icode = ic; p_valE = ve; p_valM = exp_valM; p_dstE = de; p_dstM = dm;
            have_prev  = 1'b1;
            cur_w_stat = exp_mstat;
        end
        nop();
        checks++; if (W_stat !== p_stat || W_icode !== p_icode || W_valM !== p_valM) begin errors++; $display("FAIL rnd_W_last got %h %h %h exp %h %h %h", W_stat, W_icode, W_valM, p_stat, p_icode, p_valM); end
    endtask

    initial begin
        reset = 1'b1;
        m_stall = 1'b0; m_bubble = 1'b0; w_stall = 1'b0;
        e_stat = 3'd1; e_icode = 4'd1; e_cnd = 1'b0;
        e_valE = 64'd0; e_valA = 64'd0; e_dstE = 4'hF; e_dstM = 4'hF;
        for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'h00;
        test_reset();
        test_store_load();
        test_stack();
        test_bad_addr();
        test_wrap();
        test_stall_bubble();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
